// File: rtl/dram_refresh_ctrl.sv
// -----------------------------------------------------------------------------
// dram_refresh_ctrl
//
// Periodic DDR4 refresh scheduler placed directly upstream of dram_command.
// Counts tREFI intervals, accumulates owed refreshes (up to the DDR4 8-deep
// postpone window plus one), and raises REFRESH when the scheduler is idle or
// when the owed count has become urgent. After each accepted REF command it
// holds ref_blocking for tRFC cycles so the scheduler keeps the bus quiet.
//
// Ports:
//   CLK           in   system clock, all logic on posedge
//   nRST          in   asynchronous active-low reset
//   init_done     in   DRAM init complete; refresh tracking runs only while high
//   dram_busy     in   scheduler has a read/write in flight
//   ref_ack       in   one-cycle pulse: REF command issued on the DDR4 bus
//   REFRESH       out  refresh request to dram_command
//   ref_urgent    out  owed count >= MAX_POSTPONE; scheduler must stop new work
//   ref_blocking  out  high for tRFC cycles after each accepted ref_ack
//   pending_cnt   out  owed refreshes, 0..MAX_POSTPONE+1
//   ref_overflow  out  sticky: a tick arrived with the owed count already full
// -----------------------------------------------------------------------------
module dram_refresh_ctrl #(
  parameter int unsigned TREFI_CYC    = 6240,
  parameter int unsigned TRFC_CYC     = 280,
  parameter int unsigned MAX_POSTPONE = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       init_done,
  input  logic       dram_busy,
  input  logic       ref_ack,
  output logic       REFRESH,
  output logic       ref_urgent,
  output logic       ref_blocking,
  output logic [3:0] pending_cnt,
  output logic       ref_overflow
);

  localparam logic [CNT_W-1:0] IVL_LAST = CNT_W'(TREFI_CYC - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(TRFC_CYC - 1);
  localparam logic [3:0]       PEND_URG = 4'(MAX_POSTPONE);
  localparam logic [3:0]       PEND_MAX = 4'(MAX_POSTPONE + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RFC = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ivl_cnt, ivl_nxt;
  logic [CNT_W-1:0] rfc_cnt, rfc_nxt;
  logic [3:0]       pending, pending_nxt;
  logic             ovf, ovf_nxt;
  logic             tick;
  logic             ack_acc;

  // Owed-refresh update: add one per tick, remove one per accepted ack, and
  // clamp into 0..MAX_POSTPONE+1. The signed intermediate keeps the
  // underflow case explicit even though an ack is only accepted with a
  // nonzero count.
  function automatic logic [3:0] sat_pending(input logic [3:0] cur,
                                             input logic       inc,
                                             input logic       dec);
    logic signed [5:0] sum;
    sum = $signed({2'b00, cur}) + $signed({5'b00000, inc})
        - $signed({5'b00000, dec});
    if (sum > $signed({2'b00, PEND_MAX})) begin
      return PEND_MAX;
    end
    if (sum < 6'sd0) begin
      return 4'd0;
    end
    return sum[3:0];
  endfunction

  // Interval counter: one-cycle tick on the last count of each tREFI window,
  // so the first tick lands TREFI_CYC cycles after init_done rises.
  assign tick    = init_done && (ivl_cnt == IVL_LAST);
  assign ack_acc = (state == REQ) && ref_ack;

  always_comb begin
    ivl_nxt = ivl_cnt + 1'b1;
    if (!init_done || tick) begin
      ivl_nxt = '0;
    end
  end

  always_comb begin
    pending_nxt = sat_pending(pending, tick, ack_acc);
    if (!init_done) begin
      pending_nxt = 4'd0;
    end
  end

  // Overflow is sticky across init_done drops; only nRST clears it.
  assign ovf_nxt = ovf || (tick && (pending == PEND_MAX));

  // Next-state and output decode
  always_comb begin
    state_nxt    = state;
    rfc_nxt      = rfc_cnt;
    REFRESH      = 1'b0;
    ref_blocking = 1'b0;
    ref_urgent   = (pending >= PEND_URG);
    pending_cnt  = pending;
    ref_overflow = ovf;

    unique case (state)
      IDLE: begin
        if ((pending != 4'd0) && (!dram_busy || ref_urgent)) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        REFRESH = 1'b1;
        // Held until acknowledged regardless of dram_busy: once the request
        // is on the wire dram_command owns the decision.
        if (ref_ack) begin
          state_nxt = WAIT_RFC;
          rfc_nxt   = RFC_LOAD;
        end
      end
      WAIT_RFC: begin
        ref_blocking = 1'b1;
        // Always leave through IDLE, guaranteeing one idle cycle between
        // back-to-back refresh requests.
        if (rfc_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          rfc_nxt = rfc_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (!init_done) begin
      state_nxt = IDLE;
      rfc_nxt   = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      ivl_cnt <= '0;
      rfc_cnt <= '0;
      pending <= 4'd0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      ivl_cnt <= ivl_nxt;
      rfc_cnt <= rfc_nxt;
      pending <= pending_nxt;
      ovf     <= ovf_nxt;
    end
  end

endmodule

// File: doc/dram_refresh_ctrl.md
Name: dram_refresh_ctrl

Overview:
- Periodic refresh scheduler that sits directly upstream of dram_command and drives its REFRESH request input.
- Counts tREFI intervals and accumulates owed refreshes, up to the DDR4 8-deep postpone limit.
- Defers each refresh while the scheduler has a request in flight. Forces the refresh once the postpone limit is reached.
- Blocks new scheduler traffic for tRFC after each refresh command is accepted.

Parameters:
- TREFI_CYC, 6240: refresh interval in CLK cycles (7.8 us at 1.25 ns).
- TRFC_CYC, 280: refresh cycle time in CLK cycles (350 ns at 1.25 ns).
- MAX_POSTPONE, 8: owed-refresh count at which the refresh becomes urgent.
- CNT_W, 16: width of the interval and tRFC counters; must hold TREFI_CYC-1.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- nRST  in  1  asynchronous active-low reset.
- init_done  in  1  DRAM power-up/init sequence complete; refresh tracking runs only while high.
- dram_busy  in  1  scheduler/dram_command has a read or write in flight (ramREN/ramWEN activity).
- ref_ack  in  1  single-cycle pulse from dram_command: REF command issued on the DDR4 bus.
- REFRESH  out  1  refresh request to dram_command.
- ref_urgent  out  1  pending >= MAX_POSTPONE; scheduler must stop issuing new requests.
- ref_blocking  out  1  high from ref_ack through the end of tRFC; scheduler holds all requests.
- pending_cnt  out  4  number of owed refreshes, 0..MAX_POSTPONE+1.
- ref_overflow  out  1  sticky error: a tick arrived while pending was already MAX_POSTPONE+1.

Behaviour:
- Reset (nRST low, asynchronous):
  - All outputs 0.
  - Interval counter 0, tRFC counter 0, state IDLE.
- init_done low (synchronous):
  - Interval counter, pending and state return to their reset values.
  - ref_overflow is retained.
  - A deassertion mid-WAIT_RFC aborts to IDLE with ref_blocking low on the next cycle.
- Interval counter:
  - Increments each cycle while init_done is high.
  - At TREFI_CYC-1 it wraps to 0 and generates a one-cycle internal tick.
  - The first tick occurs TREFI_CYC cycles after init_done rises.
- pending update each cycle: pending + tick - (ref_ack accepted in REQ).
  - Tick and ack in the same cycle leave pending unchanged.
  - On a tick with pending == MAX_POSTPONE+1: pending saturates and ref_overflow is set until reset.
- ref_urgent is combinational: (pending >= MAX_POSTPONE).
- State machine (registered state):
  - IDLE to REQ when pending > 0 and (!dram_busy or ref_urgent).
    - REFRESH rises the cycle after the condition holds (one-cycle latency).
  - REQ: REFRESH held high until ref_ack, regardless of dram_busy.
    - On ref_ack: pending decrements, the tRFC counter loads TRFC_CYC-1, next state WAIT_RFC.
    - REFRESH drops in the cycle after ref_ack.
  - WAIT_RFC: ref_blocking high and REFRESH low. The counter decrements each cycle; at 0, next state IDLE.
  - ref_blocking is high for exactly TRFC_CYC cycles, starting the cycle after ref_ack.
  - WAIT_RFC to REQ is permitted only via IDLE. This gives a minimum of one IDLE cycle between consecutive REFRESH requests.
- ref_ack outside REQ is ignored: no pending change, no state change.
- Ticks continue to accumulate in every state.

Test Plan (TREFI_CYC=100, TRFC_CYC=10, MAX_POSTPONE=8):
1. Reset, then init_done=1, dram_busy=0, ref_ack pulses 2 cycles after each REFRESH rise -> REFRESH rises at cycle 101 after init_done; pending 1 then 0; ref_blocking high 10 cycles; repeats every 100 cycles.
2. dram_busy=1 for 850 cycles -> pending counts up to 8; REFRESH stays low until pending=8 (cycle 800); ref_urgent=1; REFRESH asserts despite busy; after 8 acks pending=0 and ref_urgent=0.
3. dram_busy=1 permanently, never ack -> pending reaches 9; next tick (cycle 1000) sets ref_overflow=1 and pending holds 9; ref_overflow survives an init_done toggle and clears only on nRST.
4. Arrange a tick in the same cycle as ref_ack with pending=3 -> pending stays 3; state goes to WAIT_RFC.
5. nRST low mid-WAIT_RFC (cycle 5 of 10) -> ref_blocking, REFRESH and pending_cnt are 0 immediately, with no clock edge needed.
6. ref_ack pulsed while IDLE with pending=0 -> no change to pending, state or outputs.
